// File: rtl/dvi_pkg.sv
// Shared DVI definitions: feeder FSM states, pixel defaults and the standard
// video timings used by both the timing generator and the pixel feeder.
package dvi_pkg;

  localparam int          DATA_W_DEF          = 24;
  localparam int          FIFO_DEPTH_DEF      = 16;
  localparam logic [23:0] UNDERFLOW_COLOR_DEF = 24'hFF00FF;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ALIGN   = 2'd1,
    STREAM  = 2'd2
  } feeder_state_e;

  typedef struct packed {
    logic [15:0] hActive;
    logic [15:0] hFront;
    logic [15:0] hSync;
    logic [15:0] hBack;
    logic [15:0] vActive;
    logic [15:0] vFront;
    logic [15:0] vSync;
    logic [15:0] vBack;
  } video_timing_t;

  localparam video_timing_t TIMING_720P = '{
    hActive: 16'd1280, hFront: 16'd110, hSync: 16'd40, hBack: 16'd220,
    vActive: 16'd720,  vFront: 16'd5,   vSync: 16'd5,  vBack: 16'd20
  };

  localparam video_timing_t TIMING_600P = '{
    hActive: 16'd800, hFront: 16'd40, hSync: 16'd128, hBack: 16'd88,
    vActive: 16'd600, vFront: 16'd1,  vSync: 16'd4,   vBack: 16'd23
  };

  function automatic logic [15:0] hTotal(input video_timing_t t);
    return t.hActive + t.hFront + t.hSync + t.hBack;
  endfunction

  function automatic logic [15:0] vTotal(input video_timing_t t);
    return t.vActive + t.vFront + t.vSync + t.vBack;
  endfunction

endpackage

// File: rtl/dvi_pixel_fifo.sv
// Synchronous FIFO holding {sof, pixel} entries; head is the registered
// oldest entry, so a push becomes visible at the head one cycle later.
module dvi_pixel_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [AW:0]      r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_head   = r_mem[r_rdPtr];

  // Storage is not reset; the pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= i_data;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + AW'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + AW'(1);
      end
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/dvi_pixel_feeder.sv
// Pixel feeder between the GPU memory reader and the DVI transmitter: buffers
// pixels, locks each frame to its start-of-frame tag and flags underflow.
module dvi_pixel_feeder
  import dvi_pkg::*;
#(
  parameter int                DATA_W          = DATA_W_DEF,
  parameter int                FIFO_DEPTH      = FIFO_DEPTH_DEF,
  parameter logic              H_POL           = 1'b1,
  parameter logic              V_POL           = 1'b1,
  parameter logic [DATA_W-1:0] UNDERFLOW_COLOR = DATA_W'(UNDERFLOW_COLOR_DEF)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] pix_data,
  input  logic              pix_sof,
  input  logic              pix_valid,
  output logic              pix_ready,
  input  logic              ve,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic [DATA_W-1:0] rgb_out,
  output logic              de_out,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              underflow,
  output logic [15:0]       frame_count
);

  feeder_state_e     r_state;
  feeder_state_e     w_nextState;
  logic [DATA_W-1:0] r_rgbOut;
  logic              r_deOut;
  logic              r_hsyncOut;
  logic              r_vsyncOut;
  logic              r_underflow;
  logic [15:0]       r_frameCount;

  logic [DATA_W:0]   w_fifoHead;
  logic              w_fifoFull;
  logic              w_fifoEmpty;
  logic              w_headSof;
  logic [DATA_W-1:0] w_headData;
  logic              w_pop;
  logic              w_fault;
  logic              w_frameStart;
  logic              w_vsEdge;
  logic [DATA_W-1:0] w_rgbNext;

  dvi_pixel_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .i_push  (pix_valid),
    .i_data  ({pix_sof, pix_data}),
    .i_pop   (w_pop),
    .o_head  (w_fifoHead),
    .o_full  (w_fifoFull),
    .o_empty (w_fifoEmpty)
  );

  assign pix_ready  = !w_fifoFull;
  assign w_headSof  = w_fifoHead[DATA_W];
  assign w_headData = w_fifoHead[DATA_W-1:0];

  // The delayed vsync register doubles as the previous-cycle sample.
  assign w_vsEdge = (vsync_in == V_POL) && (r_vsyncOut != V_POL);

  always_comb begin
    w_nextState  = r_state;
    w_pop        = 1'b0;
    w_fault      = 1'b0;
    w_frameStart = 1'b0;
    w_rgbNext    = '0;
    case (r_state)
      WAIT_VS: begin
        if (ve) begin
          w_rgbNext = UNDERFLOW_COLOR;
        end
      end
      ALIGN: begin
        if (ve) begin
          if (!w_fifoEmpty && w_headSof) begin
            w_pop        = 1'b1;
            w_rgbNext    = w_headData;
            w_frameStart = 1'b1;
            w_nextState  = STREAM;
          end else begin
            w_fault     = 1'b1;
            w_rgbNext   = UNDERFLOW_COLOR;
            w_nextState = WAIT_VS;
          end
        end else if (!w_fifoEmpty && !w_headSof) begin
          w_pop = 1'b1;
        end
      end
      STREAM: begin
        if (ve) begin
          if (w_fifoEmpty || w_headSof) begin
            w_fault     = 1'b1;
            w_rgbNext   = UNDERFLOW_COLOR;
            w_nextState = WAIT_VS;
          end else begin
            w_pop     = 1'b1;
            w_rgbNext = w_headData;
          end
        end
      end
      default: begin
        w_nextState = WAIT_VS;
      end
    endcase
    // A new vsync always restarts alignment unless this very cycle locked a frame.
    if (w_vsEdge && !w_frameStart) begin
      w_nextState = ALIGN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= WAIT_VS;
      r_rgbOut     <= '0;
      r_deOut      <= 1'b0;
      r_hsyncOut   <= ~H_POL;
      r_vsyncOut   <= ~V_POL;
      r_underflow  <= 1'b0;
      r_frameCount <= '0;
    end else begin
      r_state    <= w_nextState;
      r_rgbOut   <= w_rgbNext;
      r_deOut    <= ve;
      r_hsyncOut <= hsync_in;
      r_vsyncOut <= vsync_in;
      if (w_fault) begin
        r_underflow <= 1'b1;
      end else if (w_vsEdge) begin
        r_underflow <= 1'b0;
      end
      if (w_frameStart) begin
        r_frameCount <= r_frameCount + 16'd1;
      end
    end
  end

  assign rgb_out     = r_rgbOut;
  assign de_out      = r_deOut;
  assign hsync_out   = r_hsyncOut;
  assign vsync_out   = r_vsyncOut;
  assign underflow   = r_underflow;
  assign frame_count = r_frameCount;

endmodule

// File: tb/tb_dvi_pixel_feeder.sv
// Directed bench for dvi_pixel_feeder using a miniature 8x4 video timing so
// whole frames fit in a few hundred cycles.
module tb_dvi_pixel_feeder;

  localparam int H_ACT = 8;
  localparam int H_FP  = 2;
  localparam int H_SY  = 2;
  localparam int HTOT  = 14;
  localparam int V_ACT = 4;
  localparam int V_FP  = 1;
  localparam int V_SY  = 1;
  localparam int VTOT  = 7;
  localparam logic [23:0] UF = 24'hFF00FF;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [23:0] pix_data = '0;
  logic        pix_sof = 1'b0;
  logic        pix_valid = 1'b0;
  logic        pix_ready;
  logic        ve = 1'b0;
  logic        hsync_in = 1'b0;
  logic        vsync_in = 1'b0;
  logic [23:0] rgb_out;
  logic        de_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        underflow;
  logic [15:0] frame_count;

  dvi_pixel_feeder #(
    .DATA_W          (24),
    .FIFO_DEPTH      (16),
    .H_POL           (1'b1),
    .V_POL           (1'b1),
    .UNDERFLOW_COLOR (24'hFF00FF)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .pix_data    (pix_data),
    .pix_sof     (pix_sof),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .ve          (ve),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .rgb_out     (rgb_out),
    .de_out      (de_out),
    .hsync_out   (hsync_out),
    .vsync_out   (vsync_out),
    .underflow   (underflow),
    .frame_count (frame_count)
  );

  always #5 clock = ~clock;

  int          total = 0;
  int          bad = 0;
  int          hc = 0;
  int          vc = 0;
  int          ufAt = -1;
  int          pushCount = 0;
  bit          timingOn = 1'b0;
  bit          upOn = 1'b0;
  bit          chk = 1'b0;
  bit          chkReadyOnDe = 1'b0;
  logic        prevVe = 1'b0;
  logic        prevH = 1'b0;
  logic        prevV = 1'b0;
  logic [24:0] srcQ[$];
  logic [23:0] gotQ[$];

  function automatic logic [23:0] pixVal(input int f, input int i);
    return {f[7:0], i[7:0], 8'h5A};
  endfunction

  function automatic logic [23:0] gotAt(input int i);
    if (i < gotQ.size()) return gotQ[i];
    return 24'hxxxxxx;
  endfunction

  task automatic addFrame(input int f, input int n);
    for (int i = 0; i < n; i++) srcQ.push_back({(i == 0), pixVal(f, i)});
  endtask

  task automatic addJunk(input int n);
    for (int i = 0; i < n; i++) srcQ.push_back({1'b0, 8'hEE, i[7:0], 8'h11});
  endtask

  // One pixel clock: drive timing and upstream, then observe just after the edge.
  task automatic step();
    logic pushWill;
    if (timingOn) begin
      ve       = (hc < H_ACT) && (vc < V_ACT);
      hsync_in = (hc >= H_ACT + H_FP) && (hc < H_ACT + H_FP + H_SY);
      vsync_in = (vc >= V_ACT + V_FP) && (vc < V_ACT + V_FP + V_SY);
    end else begin
      ve = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    end
    if (upOn && srcQ.size() > 0) begin
      pix_valid = 1'b1; pix_sof = srcQ[0][24]; pix_data = srcQ[0][23:0];
    end else begin
      pix_valid = 1'b0; pix_sof = 1'b0; pix_data = '0;
    end
    pushWill = pix_valid && pix_ready;
    prevVe = ve; prevH = hsync_in; prevV = vsync_in;
    @(posedge clock); #1;
    if (pushWill) begin
      void'(srcQ.pop_front());
      pushCount++;
    end
    if (timingOn) begin
      hc++;
      if (hc == HTOT) begin
        hc = 0;
        vc = (vc == VTOT - 1) ? 0 : vc + 1;
      end
    end
    if (chk) begin
      total++;
      if (de_out !== prevVe) begin bad++; $display("[TB] FAIL de_delay: got %b want %b", de_out, prevVe); end
      total++;
      if (hsync_out !== prevH) begin bad++; $display("[TB] FAIL hsync_delay: got %b want %b", hsync_out, prevH); end
      total++;
      if (vsync_out !== prevV) begin bad++; $display("[TB] FAIL vsync_delay: got %b want %b", vsync_out, prevV); end
      if (de_out === 1'b1) begin
        gotQ.push_back(rgb_out);
        if (underflow === 1'b1 && ufAt < 0) ufAt = gotQ.size() - 1;
        if (chkReadyOnDe) begin
          total++;
          if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_after_pop: got %b want 1", pix_ready); end
        end
      end
    end
  endtask

  task automatic runSteps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic runFrame();
    int n = 0;
    do begin
      step();
      n++;
    end while (!(hc == 0 && vc == V_ACT) && n < 2 * VTOT * HTOT);
  endtask

  task automatic test_reset();
    #1 reset = 1'b1;
    #1;
    total++; if (rgb_out !== 24'h0) begin bad++; $display("[TB] FAIL reset_rgb: got %h want 000000", rgb_out); end
    total++; if (de_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_de: got %b want 0", de_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_hsync: got %b want 0", hsync_out); end
    total++; if (vsync_out !== 1'b0) begin bad++; $display("[TB] FAIL reset_vsync: got %b want 0", vsync_out); end
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL reset_underflow: got %b want 0", underflow); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL reset_frames: got %0d want 0", frame_count); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b want 1", pix_ready); end
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  task automatic test_fifo_full();
    addFrame(1, 32);
    addFrame(2, 32);
    upOn = 1'b1; chk = 1'b1; pushCount = 0;
    runSteps(15);
    total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL ready_at_15: got %b want 1", pix_ready); end
    step();
    total++; if (pix_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_at_16: got %b want 0", pix_ready); end
    total++; if (pushCount != 16) begin bad++; $display("[TB] FAIL pushes_to_full: got %0d want 16", pushCount); end
    runSteps(3);
    total++; if (pix_ready !== 1'b0) begin bad++; $display("[TB] FAIL ready_held_full: got %b want 0", pix_ready); end
    total++; if (pushCount != 16) begin bad++; $display("[TB] FAIL pushes_blocked: got %0d want 16", pushCount); end
  endtask

  task automatic test_stream();
    timingOn = 1'b1; hc = 0; vc = V_ACT;
    gotQ.delete(); ufAt = -1; chkReadyOnDe = 1'b1;
    runSteps(3 * HTOT);
    total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL frames_before_active: got %0d want 0", frame_count); end
    runSteps(HTOT);
    total++; if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL frames_after_line0: got %0d want 1", frame_count); end
    total++; if (gotQ.size() != 8) begin bad++; $display("[TB] FAIL pixels_line0: got %0d want 8", gotQ.size()); end
    runFrame();
    chkReadyOnDe = 1'b0;
    total++; if (gotQ.size() != 32) begin bad++; $display("[TB] FAIL stream_count: got %0d want 32", gotQ.size()); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (gotAt(i) !== pixVal(1, i)) begin bad++; $display("[TB] FAIL stream_px%0d: got %h want %h", i, gotAt(i), pixVal(1, i)); end
    end
    total++; if (ufAt != -1) begin bad++; $display("[TB] FAIL stream_underflow: flagged at px %0d want none", ufAt); end
  endtask

  task automatic test_underflow_stall();
    logic [23:0] exp;
    upOn = 1'b0; gotQ.delete(); ufAt = -1;
    runFrame();
    total++; if (gotQ.size() != 32) begin bad++; $display("[TB] FAIL stall_count: got %0d want 32", gotQ.size()); end
    for (int i = 0; i < 32; i++) begin
      exp = (i < 16) ? pixVal(2, i) : UF;
      total++;
      if (gotAt(i) !== exp) begin bad++; $display("[TB] FAIL stall_px%0d: got %h want %h", i, gotAt(i), exp); end
    end
    total++; if (ufAt != 16) begin bad++; $display("[TB] FAIL stall_uf_pos: got %0d want 16", ufAt); end
    total++; if (underflow !== 1'b1) begin bad++; $display("[TB] FAIL stall_sticky: got %b want 1", underflow); end
    total++; if (frame_count !== 16'd2) begin bad++; $display("[TB] FAIL stall_frames: got %0d want 2", frame_count); end
    upOn = 1'b1; addFrame(3, 32); gotQ.delete(); ufAt = -1;
    runSteps(2 * HTOT);
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL stall_clear_on_vs: got %b want 0", underflow); end
    runFrame();
    total++; if (gotQ.size() != 32) begin bad++; $display("[TB] FAIL realign_count: got %0d want 32", gotQ.size()); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (gotAt(i) !== pixVal(3, i)) begin bad++; $display("[TB] FAIL realign_px%0d: got %h want %h", i, gotAt(i), pixVal(3, i)); end
    end
    total++; if (ufAt != -1) begin bad++; $display("[TB] FAIL realign_underflow: flagged at px %0d want none", ufAt); end
    total++; if (frame_count !== 16'd3) begin bad++; $display("[TB] FAIL realign_frames: got %0d want 3", frame_count); end
  endtask

  task automatic test_align_junk();
    addJunk(5); addFrame(4, 32); gotQ.delete(); ufAt = -1;
    runFrame();
    total++; if (gotQ.size() != 32) begin bad++; $display("[TB] FAIL junk_count: got %0d want 32", gotQ.size()); end
    for (int i = 0; i < 32; i++) begin
      total++;
      if (gotAt(i) !== pixVal(4, i)) begin bad++; $display("[TB] FAIL junk_px%0d: got %h want %h", i, gotAt(i), pixVal(4, i)); end
    end
    total++; if (ufAt != -1) begin bad++; $display("[TB] FAIL junk_underflow: flagged at px %0d want none", ufAt); end
    total++; if (frame_count !== 16'd4) begin bad++; $display("[TB] FAIL junk_frames: got %0d want 4", frame_count); end
  endtask

  task automatic test_short_frame();
    logic [23:0] exp;
    addFrame(5, 22); addFrame(6, 32); gotQ.delete(); ufAt = -1;
    runFrame();
    for (int i = 0; i < 32; i++) begin
      exp = (i < 22) ? pixVal(5, i) : UF;
      total++;
      if (gotAt(i) !== exp) begin bad++; $display("[TB] FAIL short_px%0d: got %h want %h", i, gotAt(i), exp); end
    end
    total++; if (ufAt != 22) begin bad++; $display("[TB] FAIL short_uf_pos: got %0d want 22", ufAt); end
    total++; if (frame_count !== 16'd5) begin bad++; $display("[TB] FAIL short_frames: got %0d want 5", frame_count); end
    addFrame(7, 32); gotQ.delete(); ufAt = -1;
    runFrame();
    for (int i = 0; i < 32; i++) begin
      total++;
      if (gotAt(i) !== pixVal(6, i)) begin bad++; $display("[TB] FAIL next_sof_px%0d: got %h want %h", i, gotAt(i), pixVal(6, i)); end
    end
    total++; if (ufAt != -1) begin bad++; $display("[TB] FAIL next_sof_underflow: flagged at px %0d want none", ufAt); end
    total++; if (frame_count !== 16'd6) begin bad++; $display("[TB] FAIL next_sof_frames: got %0d want 6", frame_count); end
  endtask

  task automatic test_async_reset();
    runSteps(4 * HTOT + 3);
    total++; if (frame_count !== 16'd7) begin bad++; $display("[TB] FAIL pre_reset_frames: got %0d want 7", frame_count); end
    total++; if (de_out !== 1'b1) begin bad++; $display("[TB] FAIL pre_reset_de: got %b want 1", de_out); end
    #2 reset = 1'b1;
    #1;
    total++; if (rgb_out !== 24'h0) begin bad++; $display("[TB] FAIL async_rgb: got %h want 000000", rgb_out); end
    total++; if (de_out !== 1'b0) begin bad++; $display("[TB] FAIL async_de: got %b want 0", de_out); end
    total++; if (hsync_out !== 1'b0) begin bad++; $display("[TB] FAIL async_hsync: got %b want 0", hsync_out); end
    total++; if (vsync_out !== 1'b0) begin bad++; $display("[TB] FAIL async_vsync: got %b want 0", vsync_out); end
    total++; if (underflow !== 1'b0) begin bad++; $display("[TB] FAIL async_underflow: got %b want 0", underflow); end
    total++; if (frame_count !== 16'd0) begin bad++; $display("[TB] FAIL async_frames: got %0d want 0", frame_count); end
    total++; if (pix_ready !== 1'b1) begin bad++; $display("[TB] FAIL async_ready: got %b want 1", pix_ready); end
    chk = 1'b0; upOn = 1'b0;
    runSteps(2);
    reset = 1'b0;
    chk = 1'b1; upOn = 1'b1;
    addFrame(8, 32); gotQ.delete(); ufAt = -1;
    runFrame();
    total++; if (gotQ.size() != 19) begin bad++; $display("[TB] FAIL post_reset_count: got %0d want 19", gotQ.size()); end
    for (int i = 0; i < 19; i++) begin
      total++;
      if (gotAt(i) !== UF) begin bad++; $display("[TB] FAIL post_reset_px%0d: got %h want %h", i, gotAt(i), UF); end
    end
    total++; if (ufAt != -1) begin bad++; $display("[TB] FAIL post_reset_underflow: flagged at px %0d want none", ufAt); end
    gotQ.delete();
    runFrame();
    for (int i = 0; i < 32; i++) begin
      total++;
      if (gotAt(i) !== pixVal(8, i)) begin bad++; $display("[TB] FAIL post_reset_align_px%0d: got %h want %h", i, gotAt(i), pixVal(8, i)); end
    end
    total++; if (frame_count !== 16'd1) begin bad++; $display("[TB] FAIL post_reset_frames: got %0d want 1", frame_count); end
  endtask

  initial begin
    test_reset();
    test_fifo_full();
    test_stream();
    test_underflow_stall();
    test_align_junk();
    test_short_frame();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
